// File: rtl/head_insert.sv
// head_insert: prepends up to BYTES-1 insert bytes to a packet stream, realigning every beat
// and emitting a flush beat on overflow. Define HEAD_INSERT_ERR_CHECK_EN for the sticky o_err flag.
module head_insert #(
    parameter int DATA_W = 512,
    localparam int BYTES = DATA_W / 8,
    localparam int LEN_W = $clog2(BYTES) + 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_start,
    input  logic              i_tail,
    input  logic [DATA_W-1:0] i_data,
    input  logic [LEN_W-1:0]  i_tailBytes,
    input  logic [LEN_W-1:0]  i_insLen,
    input  logic [DATA_W-1:0] i_insData,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_start,
    output logic              o_tail,
    output logic [DATA_W-1:0] o_data,
    output logic [LEN_W-1:0]  o_tailBytes,
    output logic              o_err
);

    typedef enum logic [1:0] {IDLE, BODY, FLUSH} state_t;

    state_t            state;
    logic [DATA_W-1:0] carry_p1;
    logic [LEN_W-1:0]  len_p1;
    logic [LEN_W-1:0]  flush_len_p1;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] n);
        clamp_len = (n >= LEN_W'(BYTES)) ? LEN_W'(BYTES - 1) : n;
    endfunction

    // Mask keeping the n most-significant bytes of a beat.
    function automatic logic [DATA_W-1:0] keep_mask(input logic [LEN_W:0] n);
        keep_mask = ~({DATA_W{1'b1}} >> {n, 3'b000});
    endfunction

    logic              out_free;
    logic              acc_in;
    logic [LEN_W-1:0]  cur_len;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] beat_full;
    logic [DATA_W-1:0] next_carry;
    logic [LEN_W:0]    sum;
    logic              fits;

    assign out_free   = !o_valid | i_ready;
    assign o_ready    = (state != FLUSH) & out_free;
    assign acc_in     = i_valid & o_ready;
    assign cur_len    = i_start ? clamp_len(i_insLen) : len_p1;
    assign head       = i_start ? (i_insData & keep_mask({1'b0, cur_len})) : carry_p1;
    assign beat_full  = head | (i_data >> {cur_len, 3'b000});
    assign next_carry = i_data << {LEN_W'(BYTES) - cur_len, 3'b000};
    assign sum        = {1'b0, i_tailBytes} + {1'b0, cur_len};
    assign fits       = sum <= (LEN_W + 1)'(BYTES);

    // Output stage p1: registered beat, one cycle after the input transfer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            o_valid      <= 1'b0;
            o_start      <= 1'b0;
            o_tail       <= 1'b0;
            o_data       <= '0;
            o_tailBytes  <= '0;
            carry_p1     <= '0;
            len_p1       <= '0;
            flush_len_p1 <= '0;
        end else begin
            if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
            if (state == FLUSH) begin
                if (out_free) begin
                    o_valid     <= 1'b1;
                    o_start     <= 1'b0;
                    o_tail      <= 1'b1;
                    o_data      <= carry_p1 & keep_mask({1'b0, flush_len_p1});
                    o_tailBytes <= flush_len_p1;
                    state       <= IDLE;
                end
            end else if (acc_in && (i_start || state == BODY)) begin
                o_valid  <= 1'b1;
                o_start  <= i_start;
                len_p1   <= cur_len;
                carry_p1 <= next_carry;
                if (!i_tail) begin
                    o_tail      <= 1'b0;
                    o_data      <= beat_full;
                    o_tailBytes <= '0;
                    state       <= BODY;
                end else if (fits) begin
                    o_tail      <= 1'b1;
                    o_data      <= beat_full & keep_mask(sum);
                    o_tailBytes <= sum[LEN_W-1:0];
                    state       <= IDLE;
                end else begin
                    // Overflow: this beat is full, the residual goes out in a flush beat.
                    o_tail       <= 1'b0;
                    o_data       <= beat_full;
                    o_tailBytes  <= '0;
                    flush_len_p1 <= LEN_W'(sum - (LEN_W + 1)'(BYTES));
                    state        <= FLUSH;
                end
            end
        end
    end

`ifdef HEAD_INSERT_ERR_CHECK_EN
    logic err_now;

    assign err_now = acc_in & ((!i_start & (state == IDLE))
                             | (i_start & (state == BODY))
                             | (i_start & (i_insLen >= LEN_W'(BYTES)))
                             | (i_tail & ((i_tailBytes == '0) | (i_tailBytes > LEN_W'(BYTES)))));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_err <= 1'b0;
        end else if (err_now) begin
            o_err <= 1'b1;
        end
    end
`else
    assign o_err = 1'b0;
`endif

endmodule
